// File: rtl/pwm_pkg.sv
// Shared constants, pin-mode encoding and helpers for the PWM output stage.
package pwm_pkg;

  localparam int unsigned PWM_STEPS       = 255;
  localparam int unsigned DEFAULT_CLK_DIV = 13;
  localparam logic [7:0]  DUTY_ALWAYS_ON  = 8'hFF;

  typedef enum logic [1:0] {
    PIN_OFF,
    PIN_STATIC,
    PIN_PWM
  } pin_mode_e;

  function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
    pin_mode_e mode;
    if (!en_out) begin
      mode = PIN_OFF;
    end else if (!en_pwm) begin
      mode = PIN_STATIC;
    end else begin
      mode = PIN_PWM;
    end
    return mode;
  endfunction

  // 0xFF is special-cased so that full scale never has a low step.
  function automatic logic pwm_compare(input logic [7:0] cnt, input logic [7:0] duty);
    return (duty == DUTY_ALWAYS_ON) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clk prescaler feeding a 0..PWM_STEPS-1 step counter.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int unsigned PWM_STEPS = pwm_pkg::PWM_STEPS
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick_o,
  output logic [7:0] pwm_cnt_o,
  output logic       wrap_o
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [7:0]       CNT_LAST = 8'(PWM_STEPS - 1);

  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             tick;
  logic             wrap;

  assign tick = (prescaler_q == PRE_LAST);
  assign wrap = tick && (cnt_q == CNT_LAST);

  always_comb begin
    prescaler_d = prescaler_q + PRE_W'(1);
    cnt_d       = cnt_q;
    if (tick) begin
      prescaler_d = '0;
      cnt_d       = wrap ? '0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      cnt_q       <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tick_o    = tick;
  assign pwm_cnt_o = cnt_q;
  assign wrap_o    = wrap;

endmodule

// File: rtl/pwm_output_stage.sv
// 16-pin output stage: each pin off, static high or shared PWM; registered drive.
// Optional macro PWM_SYNC_UPDATE_EN double-buffers the duty cycle at period wrap.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int unsigned PWM_STEPS = pwm_pkg::PWM_STEPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic [7:0]  pwm_cnt;
  logic        wrap;
  logic        tick_unused;
  logic [7:0]  active_duty;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_q, out_d;
  logic        period_start_q, period_start_d;

  pwm_timebase #(
    .CLK_DIV   (CLK_DIV),
    .PWM_STEPS (PWM_STEPS)
  ) u_timebase (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_o    (tick_unused),
    .pwm_cnt_o (pwm_cnt),
    .wrap_o    (wrap)
  );

`ifdef PWM_SYNC_UPDATE_EN
  logic [7:0] active_duty_q, active_duty_d;

  // New duty is taken only as the counter wraps, so every period is whole.
  always_comb begin
    active_duty_d = active_duty_q;
    if (wrap) begin
      active_duty_d = pwm_duty_cycle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_duty_q <= '0;
    end else begin
      active_duty_q <= active_duty_d;
    end
  end

  assign active_duty = active_duty_q;
`else
  assign active_duty = pwm_duty_cycle;
`endif

  assign pwm_sig = pwm_compare(pwm_cnt, active_duty);
  assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    out_d          = '0;
    period_start_d = wrap;
    for (int unsigned i = 0; i < 16; i++) begin
      case (pin_mode(en_out[i], en_pwm[i]))
        PIN_OFF:    out_d[i] = 1'b0;
        PIN_STATIC: out_d[i] = 1'b1;
        PIN_PWM:    out_d[i] = pwm_sig;
        default:    out_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed self-checking bench for pwm_output_stage with a scoreboard of expectations.
module tb_pwm_output_stage;

  localparam int CLK_DIV = 13;
  localparam int PER     = 255 * CLK_DIV;  // 3315 clk per PWM period
`ifdef PWM_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_start;

  always #5 clk = ~clk;

  pwm_output_stage #(
    .CLK_DIV   (CLK_DIV),
    .PWM_STEPS (255)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  int          ones[16];
  int          ps_cnt, last_ps, ps_space, changes, misalign, cyc;
  logic [15:0] prev_out;
  bit          meas_on = 1'b0;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL sb_underflow observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
    duty = d;
  endtask

  task automatic clear_meas();
    for (int i = 0; i < 16; i++) ones[i] = 0;
    ps_cnt   = 0;
    last_ps  = -1;
    ps_space = 0;
    changes  = 0;
    misalign = 0;
    prev_out = out;
    meas_on  = 1'b1;
  endtask

  task automatic step();
    logic [3:0] grp;
    @(negedge clk);
    cyc++;
    if (meas_on) begin
      for (int i = 0; i < 16; i++) ones[i] += int'(out[i]);
      if (out !== prev_out) changes++;
      prev_out = out;
      if (period_start === 1'b1) begin
        if (last_ps >= 0) ps_space = cyc - last_ps;
        last_ps = cyc;
        ps_cnt++;
      end
      grp = {out[15], out[13], out[11], out[9]};
      if (grp != 4'h0 && grp != 4'hF) misalign++;
    end
  endtask

  // Leaves the bench at the negedge where period_start is high.
  task automatic align();
    int n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < 4000);
    push("align_ps", 1);
    check(32'(period_start));
  endtask

  initial begin
    int n;
    int other;
    cyc = 0;
    rst_n = 1'b0;
    set_in(16'hFFFF, 16'hFFFF, 8'hFF);

    repeat (10) begin
      step();
      push("rst_out", 0);
      check(32'(out));
      push("rst_ps", 0);
      check(32'(period_start));
    end

    rst_n = 1'b1;
    step();
    push("all_on", 32'hFFFF);
    check(32'(out));
    n = 1;
    while (period_start !== 1'b1 && n < 4000) begin
      step();
      n++;
    end
    push("first_ps_cycle", PER);
    check(32'(n));

    // Static high on pin 0
    set_in(16'h0001, 16'h0000, 8'h00);
    step();
    push("static_latency", 32'h0001);
    check(32'(out));
    clear_meas();
    repeat (3 * PER) step();
    push("static_high", 3 * PER);
    check(32'(ones[0]));
    other = 0;
    for (int i = 1; i < 16; i++) other += ones[i];
    push("static_others", 0);
    check(32'(other));
    push("static_changes", 0);
    check(32'(changes));
    push("static_ps_count", 3);
    check(32'(ps_cnt));
    push("ps_spacing", PER);
    check(32'(ps_space));

    // Duty 0x80
    set_in(16'h0001, 16'h0001, 8'h80);
    align();
    clear_meas();
    repeat (PER) step();
    push("duty80_high", 128 * CLK_DIV);
    check(32'(ones[0]));
    push("duty80_ps", 1);
    check(32'(ps_cnt));

    // Extremes
    set_in(16'h0001, 16'h0001, 8'h00);
    align();
    clear_meas();
    repeat (3 * PER) step();
    push("duty00_high", 0);
    check(32'(ones[0]));

    set_in(16'h0001, 16'h0001, 8'hFF);
    align();
    clear_meas();
    repeat (3 * PER) step();
    push("dutyFF_high", 3 * PER);
    check(32'(ones[0]));
    push("dutyFF_changes", 0);
    check(32'(changes));

    set_in(16'h0001, 16'h0001, 8'h01);
    align();
    clear_meas();
    repeat (PER) step();
    push("duty01_high", CLK_DIV);
    check(32'(ones[0]));

    // Mixed pin modes
    set_in(16'hFF00, 16'hAA00, 8'h40);
    align();
    clear_meas();
    repeat (PER) step();
    for (int i = 0; i < 16; i++) begin
      push($sformatf("mixed_pin%0d", i),
           (i < 8) ? 0 : ((i % 2 == 1) ? 64 * CLK_DIV : PER));
      check(32'(ones[i]));
    end
    push("mixed_misalign", 0);
    check(32'(misalign));

    // Duty change mid-period
    set_in(16'h0001, 16'h0001, 8'h40);
    align();
    clear_meas();
    repeat (1000) step();
    duty = 8'hC0;
    step();
    push("upd_next_clk", SYNC ? 0 : 1);
    check(32'(out[0]));
    repeat (PER - 1001) step();
    push("upd_cur_period", SYNC ? 832 : 2328);
    check(32'(ones[0]));
    push("upd_ps", 1);
    check(32'(ps_cnt));
    clear_meas();
    repeat (PER) step();
    push("upd_next_period", 192 * CLK_DIV);
    check(32'(ones[0]));

    // Reset mid-period
    set_in(16'hFFFF, 16'h0001, 8'hC0);
    repeat (500) step();
    push("pre_rst_static", 32'h7FFF);
    check(32'(out[15:1]));
    #2 rst_n = 1'b0;
    #1;
    push("rstmid_out", 0);
    check(32'(out));
    push("rstmid_ps", 0);
    check(32'(period_start));
    step();
    step();
    push("rstmid_hold", 0);
    check(32'(out));
    set_in(16'h0001, 16'h0001, 8'hC0);
    rst_n = 1'b1;
    clear_meas();
    n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < 4000);
    push("restart_ps_cycle", PER);
    check(32'(n));
    push("restart_duty", SYNC ? 0 : 192 * CLK_DIV);
    check(32'(ones[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
